// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel position, line/frame totals and a timing lock
// from an incoming Hsync_n/Vsync_n stream. Define VGA_ERR_COUNT_EN to build the error counter.

module vga_sync_receiver #(
  parameter int DW      = 12,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int V_TOTAL = 525
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pixelIn,
  input  logic          Hsync_n,
  input  logic          Vsync_n,
  output logic [DW-1:0] pixelOut,
  output logic          de,
  output logic [9:0]    posX,
  output logic [9:0]    posY,
  output logic          frameStart,
  output logic [9:0]    hTotal,
  output logic [9:0]    vTotal,
  output logic          locked,
  output logic [15:0]   errCount
);

  localparam logic [9:0] SAT     = 10'd1023;
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACT);
  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_SW    = 10'(H_SYNC);
  localparam logic [9:0] V_SW    = 10'(V_SYNC);

  logic [DW-1:0] pix_s1_q, pix_s1_d, pix_out_q, pix_out_d;
  logic          hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]    hcount_q, hcount_d, vcount_q, vcount_d;
  logic          h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic          de_q, de_d, frame_start_q, frame_start_d;
  logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]    h_total_q, h_total_d, v_total_q, v_total_d;
  logic          frame_clean_q, frame_clean_d, locked_q, locked_d;
  logic [1:0]    good_frames_q, good_frames_d;

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic h_line_done, v_frame_done, visible, timing_err;

  always_comb begin
    pix_s1_d  = pixelIn;
    hs_s1_d   = Hsync_n;
    vs_s1_d   = Vsync_n;
    hs_prev_d = hs_s1_q;
    vs_prev_d = vs_s1_q;

    hs_fall = hs_prev_q & ~hs_s1_q;
    hs_rise = ~hs_prev_q & hs_s1_q;
    vs_fall = vs_prev_q & ~vs_s1_q;
    vs_rise = ~vs_prev_q & vs_s1_q;

    hcount_d = hcount_q;
    if (hs_fall)              hcount_d = '0;
    else if (hcount_q != SAT) hcount_d = hcount_q + 10'd1;

    vcount_d = vcount_q;
    if (vs_fall)                          vcount_d = '0;
    else if (hs_fall && vcount_q != SAT)  vcount_d = vcount_q + 10'd1;

    // Totals and widths are only trusted once a full reference edge has been seen since reset.
    h_armed_d    = h_armed_q | hs_fall;
    v_armed_d    = v_armed_q | vs_fall;
    h_line_done  = hs_fall & h_armed_q & (hcount_q != SAT);
    v_frame_done = vs_fall & v_armed_q & (vcount_q != SAT);
    h_total_d    = h_line_done  ? hcount_q + 10'd1 : h_total_q;
    v_total_d    = v_frame_done ? vcount_q + 10'd1 : v_total_q;

    timing_err = (h_line_done && (hcount_q + 10'd1 != H_TOT))
              || (h_armed_q && !hs_fall && hcount_q == SAT - 10'd1)
              || (hs_rise && h_armed_q && hcount_d != H_SW)
              || (v_frame_done && (vcount_q + 10'd1 != V_TOT))
              || (v_armed_q && !vs_fall && hs_fall && vcount_q == SAT - 10'd1)
              || (vs_rise && v_armed_q && vcount_d != V_SW);

    visible = (hcount_d >= H_START) && (hcount_d < H_END)
           && (vcount_d >= V_START) && (vcount_d < V_END);
    pix_out_d     = visible ? pix_s1_q : '0;
    de_d          = visible;
    pos_x_d       = visible ? hcount_d - H_START : pos_x_q;
    pos_y_d       = visible ? vcount_d - V_START : pos_y_q;
    frame_start_d = visible && (hcount_d == H_START) && (vcount_d == V_START);

    // An error on the Vsync edge itself belongs to the frame that just ended.
    frame_clean_d = vs_fall | (frame_clean_q & ~timing_err);
    good_frames_d = good_frames_q;
    if (timing_err)
      good_frames_d = '0;
    else if (vs_fall && v_armed_q && frame_clean_q && good_frames_q != 2'd2)
      good_frames_d = good_frames_q + 2'd1;
    locked_d = (good_frames_d == 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_s1_q      <= '0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      hcount_q      <= SAT;
      vcount_q      <= SAT;
      h_armed_q     <= 1'b0;
      v_armed_q     <= 1'b0;
      pix_out_q     <= '0;
      de_q          <= 1'b0;
      pos_x_q       <= '0;
      pos_y_q       <= '0;
      frame_start_q <= 1'b0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      frame_clean_q <= 1'b0;
      good_frames_q <= '0;
      locked_q      <= 1'b0;
    end else begin
      pix_s1_q      <= pix_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_armed_q     <= h_armed_d;
      v_armed_q     <= v_armed_d;
      pix_out_q     <= pix_out_d;
      de_q          <= de_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      frame_start_q <= frame_start_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      frame_clean_q <= frame_clean_d;
      good_frames_q <= good_frames_d;
      locked_q      <= locked_d;
    end
  end

`ifdef VGA_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (timing_err && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign errCount = err_count_q;
`else
  assign errCount = '0;
`endif

  assign pixelOut   = pix_out_q;
  assign de         = de_q;
  assign posX       = pos_x_q;
  assign posY       = pos_y_q;
  assign frameStart = frame_start_q;
  assign hTotal     = h_total_q;
  assign vTotal     = v_total_q;
  assign locked     = locked_q;

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter: DW, 12, pixel colour width in bits.
REQ-002 SHALL have port: clk  input  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: pixelIn  input  DW  incoming pixel colour.
REQ-005 SHALL have port: Hsync_n  input  1  horizontal sync, active low.
REQ-006 SHALL have port: Vsync_n  input  1  vertical sync, active low.
REQ-007 SHALL have port: pixelOut  output  DW  captured pixel; 0 when de=0.
REQ-008 SHALL have port: de  output  1  high while pixelOut is a visible pixel.
REQ-009 SHALL have port: posX  output  10  column of pixelOut, 0..639.
REQ-010 SHALL have port: posY  output  10  row of pixelOut, 0..479.
REQ-011 SHALL have port: frameStart  output  1  one-cycle pulse with pixel (0,0).
REQ-012 SHALL have port: hTotal  output  10  length of last complete line, in clocks.
REQ-013 SHALL have port: vTotal  output  10  length of last complete frame, in lines.
REQ-014 SHALL have port: locked  output  1  timing matches 640x480@60.
REQ-015 SHALL have port: errCount  output  16  timing-error counter (see Configuration).

Function
REQ-016 SHALL register pixelIn, Hsync_n, Vsync_n once (stage 1); a sync falling edge is stage-1 value 0 with previous stage-1 value 1.
REQ-017 SHALL keep hcount (10 bit): 0 on Hsync_n falling edge, else +1, saturating at 1023.
REQ-018 SHALL keep vcount (10 bit): 0 on Vsync_n falling edge, else +1 on each Hsync_n falling edge, saturating at 1023; Vsync edge wins if both edges in the same cycle.
REQ-019 SHALL define visible as hcount in [144,784) and vcount in [35,515); posX=hcount-144, posY=vcount-35.
REQ-020 SHALL make pixelOut/de/posX/posY registered with fixed latency 2 clocks from input sample to output.
REQ-021 SHALL hold posX/posY at last visible value and drive pixelOut=0 while de=0.
REQ-022 SHALL pulse frameStart for exactly the cycle de=1 with posX=0, posY=0.
REQ-023 SHALL latch hTotal=hcount+1 on each Hsync_n falling edge when hcount<1023; a saturated line leaves hTotal unchanged and counts as an error.
REQ-024 SHALL measure Hsync low width (clocks) and Vsync low width (lines) per pulse.
REQ-025 SHALL latch vTotal=vcount+1 on each Vsync_n falling edge.
REQ-026 SHALL flag a timing error on: hTotal!=800, Hsync width!=96, vTotal!=525, Vsync width!=2, or any counter saturation.
REQ-027 SHALL assert locked after two consecutive error-free frames (Vsync edge to Vsync edge) and deassert it the cycle after any timing error.
REQ-028 SHALL keep de/pixelOut operating regardless of locked.

Reset
REQ-029 SHALL, while rst=1, force: hcount=1023, vcount=1023, pixelOut=0, de=0, posX=0, posY=0, frameStart=0, hTotal=0, vTotal=0, locked=0, errCount=0, stage-1 sync registers=1.
REQ-030 SHALL, after reset mid-frame, produce de=0 until the first Vsync_n falling edge followed by 35 Hsync_n falling edges.

Configuration
REQ-031 SHALL, with macro VGA_ERR_COUNT_EN defined, increment errCount by 1 per timing error, saturating at 65535, cleared only by rst.
REQ-032 SHALL, without VGA_ERR_COUNT_EN, tie errCount to 0 and omit the counter logic.

Verification
REQ-033 SHALL cover: 3 nominal 800x525 frames from a 640x480 timing generator -> de high 640 clocks on each of 480 lines, hTotal=800, vTotal=525, locked=1 after 2nd full frame.
REQ-034 SHALL cover: pixelIn=posX-coded ramp -> pixelOut equals input value 2 clocks later, posX 0..639, one frameStart per frame.
REQ-035 SHALL cover: one line stretched to 801 clocks -> hTotal=801, locked falls next cycle, errCount=1 (macro on) / 0 (macro off).
REQ-036 SHALL cover: Hsync_n held high 1100 clocks -> hcount saturates, de=0, error flagged, locked=0.
REQ-037 SHALL cover: rst pulsed at row 200 -> all outputs per REQ-029, de stays 0 until row 0 of next frame.
REQ-038 SHALL cover: Vsync_n and Hsync_n falling in the same cycle -> vcount=0, not 1.
